// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared sizing helpers and control state type for stream width converters
package stream_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_BUSY  = 1'b1
   } ser_state_e;

   // Counter width for RATIO beats; a single-beat word still gets a 1-bit counter.
   function automatic int beat_cnt_w(input int ratio);
      return (ratio <= 1) ? 1 : $clog2(ratio);
   endfunction

   function automatic int calc_ratio(input int wide_width, input int narrow_width);
      return wide_width / narrow_width;
   endfunction

endpackage

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - splits each WIDTH-bit word into RATIO narrower beats on a valid/ready stream
module stream_serializer
   import stream_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   input  logic                 out_ready
);

   localparam int RATIO = calc_ratio(WIDTH, OUT_WIDTH);
   localparam int CNT_W = beat_cnt_w(RATIO);
   localparam int SEL_W = beat_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

   if ((WIDTH % OUT_WIDTH) != 0 || RATIO < 1) begin : g_bad_params
      $error("stream_serializer: WIDTH must be a positive multiple of OUT_WIDTH");
   end

   ser_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;

   logic             busy;
   logic             out_fire;
   logic             in_fire;
   logic [CNT_W-1:0] beat_idx;
   logic [SEL_W-1:0] sel_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

   assign busy     = (state_q == ST_BUSY);
   assign out_valid = busy;
   assign out_last  = busy && (cnt_q == LAST_CNT);
   assign out_fire  = out_valid & out_ready;
   // Accepting on the last beat's handshake gives the zero-bubble handoff.
   assign in_ready  = ~busy | (out_fire & out_last);
   assign in_fire   = in_valid & in_ready;

   assign beat_idx = LSB_FIRST ? cnt_q : (LAST_CNT - cnt_q);
   assign sel_base = SEL_W'(32'(beat_idx) * 32'(OUT_WIDTH));
   assign out_data = word_q[sel_base +: OUT_WIDTH];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               word_d  = in_data;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (out_fire) begin
               if (!out_last) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (in_fire) begin
                  word_d = in_data;
                  cnt_d  = '0;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

endmodule

// File: tb/tb_stream_serializer.sv
// tb/tb_stream_serializer.sv - queue-model checked bench for MSB-first, LSB-first and single-beat serializers
module tb_stream_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        m_in_ready, m_out_valid, m_out_last;
   logic [7:0]  m_out_data;
   logic        l_in_ready, l_out_valid, l_out_last;
   logic [7:0]  l_out_data;

   logic        r_in_valid, r_out_ready;
   logic [31:0] r_in_data;
   logic        r_in_ready, r_out_valid, r_out_last;
   logic [31:0] r_out_data;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [31:0] data;
      bit          last;
   } beat_t;

   beat_t qm[$];
   beat_t ql[$];
   beat_t qr[$];

   always #5 clk = ~clk;

   stream_serializer #(.WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(m_in_ready),
      .out_valid(m_out_valid), .out_data(m_out_data), .out_last(m_out_last), .out_ready(out_ready)
   );

   stream_serializer #(.WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(l_in_ready),
      .out_valid(l_out_valid), .out_data(l_out_data), .out_last(l_out_last), .out_ready(out_ready)
   );

   stream_serializer #(.WIDTH(32), .OUT_WIDTH(32), .LSB_FIRST(1'b0)) u_r1 (
      .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_data(r_in_data), .in_ready(r_in_ready),
      .out_valid(r_out_valid), .out_data(r_out_data), .out_last(r_out_last), .out_ready(r_out_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: the block is a queue of pending beats; it may accept when empty or when the final beat leaves.
   always @(posedge clk) begin : model
      bit ir_m, ir_l, ir_r;
      ir_m = (qm.size() == 0) || (out_ready && qm.size() == 1);
      ir_l = (ql.size() == 0) || (out_ready && ql.size() == 1);
      ir_r = (qr.size() == 0) || (r_out_ready && qr.size() == 1);
      if (rst) begin
         qm.delete();
         ql.delete();
         qr.delete();
      end else begin
         if (qm.size() > 0 && out_ready) void'(qm.pop_front());
         if (ql.size() > 0 && out_ready) void'(ql.pop_front());
         if (qr.size() > 0 && r_out_ready) void'(qr.pop_front());
         if (in_valid && ir_m)
            for (int k = 0; k < 4; k++) qm.push_back('{32'((in_data >> (24 - 8 * k)) & 32'hFF), k == 3});
         if (in_valid && ir_l)
            for (int k = 0; k < 4; k++) ql.push_back('{32'((in_data >> (8 * k)) & 32'hFF), k == 3});
         if (r_in_valid && ir_r)
            qr.push_back('{r_in_data, 1'b1});
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         chk("msb_valid", 32'(m_out_valid), 32'(qm.size() > 0));
         chk("msb_last", 32'(m_out_last), (qm.size() > 0) ? 32'(qm[0].last) : 32'd0);
         chk("msb_in_ready", 32'(m_in_ready), 32'((qm.size() == 0) || (out_ready && qm.size() == 1)));
         if (qm.size() > 0) chk("msb_data", 32'(m_out_data), qm[0].data);
         chk("lsb_valid", 32'(l_out_valid), 32'(ql.size() > 0));
         chk("lsb_last", 32'(l_out_last), (ql.size() > 0) ? 32'(ql[0].last) : 32'd0);
         chk("lsb_in_ready", 32'(l_in_ready), 32'((ql.size() == 0) || (out_ready && ql.size() == 1)));
         if (ql.size() > 0) chk("lsb_data", 32'(l_out_data), ql[0].data);
         chk("r1_valid", 32'(r_out_valid), 32'(qr.size() > 0));
         chk("r1_last_eq_valid", 32'(r_out_last), 32'(r_out_valid));
         chk("r1_in_ready", 32'(r_in_ready), 32'((qr.size() == 0) || (r_out_ready && qr.size() == 1)));
         if (qr.size() > 0) chk("r1_data", r_out_data, qr[0].data);
      end
   end

   initial begin
      logic [7:0] em[4];
      logic [7:0] el[4];
      logic [7:0] ed[4];
      em = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      el = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      ed = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b1;
      step();
      step();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(m_out_valid), 32'd0);
      chk("rst_last", 32'(m_out_last), 32'd0);
      chk("rst_data", 32'(m_out_data), 32'd0);
      chk("rst_in_ready", 32'(m_in_ready), 32'd1);
      chk("rst_r1_data", r_out_data, 32'd0);

      // Tests 1 and 2: one word, both beat orders
      step();
      rst = 1'b0; in_valid = 1'b1; in_data = 32'hA1B2C3D4;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_msb_beat", 32'(m_out_data), 32'(em[i]));
         chk("t1_msb_last", 32'(m_out_last), 32'(i == 3));
         chk("t1_in_ready", 32'(m_in_ready), 32'(i == 3));
         chk("t2_lsb_beat", 32'(l_out_data), 32'(el[i]));
         chk("t2_lsb_last", 32'(l_out_last), 32'(i == 3));
         step();
      end
      @(negedge clk);
      chk("t1_drained", 32'(m_out_valid), 32'd0);
      chk("t1_drained_last", 32'(m_out_last), 32'd0);
      step();

      // Test 3: back-to-back words, no bubble
      in_valid = 1'b1; in_data = 32'h01020304;
      step();
      in_data = 32'h05060708;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t3_valid", 32'(m_out_valid), 32'd1);
         chk("t3_beat", 32'(m_out_data), 32'(i + 1));
         chk("t3_last", 32'(m_out_last), 32'(i == 3 || i == 7));
         if (i < 7) chk("t3_in_ready", 32'(m_in_ready), 32'(i == 3));
         step();
         if (i == 3) in_valid = 1'b0;
      end
      @(negedge clk);
      chk("t3_drained", 32'(m_out_valid), 32'd0);
      step();

      // Test 4: backpressure on B2
      in_valid = 1'b1; in_data = 32'hA1B2C3D4;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_beat0", 32'(m_out_data), 32'hA1);
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_stall_data", 32'(m_out_data), 32'hB2);
         chk("t4_stall_valid", 32'(m_out_valid), 32'd1);
         chk("t4_stall_last", 32'(m_out_last), 32'd0);
         step();
      end
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("t4_resume", 32'(m_out_data), 32'(em[i]));
         chk("t4_resume_last", 32'(m_out_last), 32'(i == 3));
         step();
      end
      @(negedge clk);
      chk("t4_drained", 32'(m_out_valid), 32'd0);
      step();

      // Test 5: reset in the middle of a word
      in_valid = 1'b1; in_data = 32'hA1B2C3D4;
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      chk("t5_pre_rst", 32'(m_out_data), 32'hB2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_valid", 32'(m_out_valid), 32'd0);
      chk("t5_in_ready", 32'(m_in_ready), 32'd1);
      chk("t5_data_cleared", 32'(m_out_data), 32'd0);
      step();
      in_valid = 1'b1; in_data = 32'hDEADBEEF;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_beat", 32'(m_out_data), 32'(ed[i]));
         chk("t5_last", 32'(m_out_last), 32'(i == 3));
         step();
      end

      // Test 6: single-beat instance under random valid/ready
      for (int c = 0; c < 1000; c++) begin
         r_in_valid = 1'($urandom_range(0, 1));
         r_in_data = $urandom;
         r_out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("t6_last_eq_valid", 32'(r_out_last), 32'(r_out_valid));
         step();
      end
      r_in_valid = 1'b0;
      r_out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("t6_drained", 32'(r_out_valid), 32'd0);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
